// File: rtl/mem_req_arb.sv
// Round-robin arbiter that funnels NUM_AGENTS read/write requesters onto one memory request port.
// Optional macro MEM_ARB_TIMEOUT_EN adds an ISSUE-state watchdog that completes a stuck request with a_err.
module mem_req_arb #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_AGENTS = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic [NUM_AGENTS-1:0]            a_valid,
  output logic [NUM_AGENTS-1:0]            a_ready,
  input  logic [NUM_AGENTS-1:0]            a_wr_rd,
  input  logic [NUM_AGENTS*ADDR_WIDTH-1:0] a_addr,
  input  logic [NUM_AGENTS*WIDTH-1:0]      a_wdata,
  output logic [NUM_AGENTS-1:0]            a_rsp_valid,
  output logic [WIDTH-1:0]                 a_rdata,
  output logic [NUM_AGENTS-1:0]            a_err,
  output logic                             m_valid,
  output logic                             m_wr_rd,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [WIDTH-1:0]                 m_wdata,
  input  logic [WIDTH-1:0]                 m_rdata,
  input  logic                             m_ready
);

  localparam int PTR_W = $clog2(NUM_AGENTS);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  if (NUM_AGENTS < 2 || NUM_AGENTS > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mem_req_arb: NUM_AGENTS must be 2..8 and TIMEOUT at least 2");
  end

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [NUM_AGENTS-1:0]   a_rsp_valid_q, a_rsp_valid_d;
  logic [WIDTH-1:0]        a_rdata_q, a_rdata_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [WIDTH-1:0]        m_wdata_q, m_wdata_d;

  logic [PTR_W:0]          cand_s;
  logic [PTR_W-1:0]        gnt_idx_s;
  logic                    gnt_found_s;
  logic                    timeout_s;
  logic [NUM_AGENTS-1:0]   owner_oh_s;

  assign owner_oh_s = NUM_AGENTS'(1) << owner_q;

  // Round-robin search starting just after the last served agent; that agent comes last.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= NUM_AGENTS; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_s >= (PTR_W+1)'(NUM_AGENTS)) begin
        cand_s = cand_s - (PTR_W+1)'(NUM_AGENTS);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && a_valid[cand_s[PTR_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Grant is only offered while idle.
  always_comb begin
    if (state_q == IDLE && gnt_found_s) begin
      a_ready = NUM_AGENTS'(1) << gnt_idx_s;
    end else begin
      a_ready = '0;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    a_rsp_valid_d = '0;
    a_rdata_d     = a_rdata_q;
    m_valid_d     = m_valid_q;
    m_wr_rd_d     = m_wr_rd_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          m_wr_rd_d = a_wr_rd[gnt_idx_s];
          m_addr_d  = a_addr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_d = a_wdata[gnt_idx_s*WIDTH +: WIDTH];
          owner_d   = gnt_idx_s;
          rr_ptr_d  = gnt_idx_s;
          m_valid_d = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          if (!m_wr_rd_q) begin
            a_rdata_d = m_rdata;
          end else begin
            a_rdata_d = a_rdata_q;
          end
          m_valid_d     = 1'b0;
          a_rsp_valid_d = owner_oh_s;
          state_d       = RESP;
        end else if (timeout_s) begin
          m_valid_d     = 1'b0;
          a_rsp_valid_d = owner_oh_s;
          state_d       = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Main state and output registers; synchronous active-low reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q       <= IDLE;
      rr_ptr_q      <= PTR_W'(NUM_AGENTS-1);
      owner_q       <= '0;
      a_rsp_valid_q <= '0;
      a_rdata_q     <= '0;
      m_valid_q     <= 1'b0;
      m_wr_rd_q     <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rdata_q     <= a_rdata_d;
      m_valid_q     <= m_valid_d;
      m_wr_rd_q     <= m_wr_rd_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_AGENTS-1:0] a_err_q, a_err_d;

  assign timeout_s = !m_ready && (cnt_q == CNT_W'(TIMEOUT-1));

  // Watchdog counts stalled ISSUE cycles; idle clears it so every ISSUE starts from zero.
  always_comb begin
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == ISSUE && !m_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (state_q == ISSUE && timeout_s) begin
      a_err_d = owner_oh_s;
    end else begin
      a_err_d = '0;
    end
  end

  // Watchdog and error-flag registers.
  always_ff @(posedge clk) begin
    if (!res) begin
      cnt_q   <= '0;
      a_err_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      a_err_q <= a_err_d;
    end
  end

  assign a_err = a_err_q;
`else
  assign timeout_s = 1'b0;
  assign a_err     = '0;
`endif

  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rdata     = a_rdata_q;
  assign m_valid     = m_valid_q;
  assign m_wr_rd     = m_wr_rd_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Scoreboard bench for mem_req_arb: per-agent request queues drive stimulus, negedge monitors check grants,
// memory-side requests and responses against hand-computed expectations.
module tb_mem_req_arb;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int NA = 2;

  logic              clk = 1'b0;
  logic              res;
  logic [NA-1:0]     a_valid, a_ready, a_wr_rd, a_rsp_valid, a_err;
  logic [NA*AW-1:0]  a_addr;
  logic [NA*W-1:0]   a_wdata;
  logic [W-1:0]      a_rdata, m_wdata, m_rdata;
  logic              m_valid, m_wr_rd, m_ready;
  logic [AW-1:0]     m_addr;

  mem_req_arb #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_AGENTS(NA), .TIMEOUT(16)) dut (
    .clk(clk), .res(res), .a_valid(a_valid), .a_ready(a_ready), .a_wr_rd(a_wr_rd),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .a_err(a_err), .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [AW-1:0] addr; logic [W-1:0] wdata; } req_t;
  typedef struct { int agent; logic chk_data; logic [W-1:0] rdata; logic err; } rsp_t;

  req_t aq0[$], aq1[$], exp_mreq[$];
  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  int   acc_cyc[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_hs_cyc = 0;

  logic [W-1:0] mem [16];
  assign m_rdata = mem[m_addr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (res && m_valid && m_ready && m_wr_rd) mem[m_addr] <= m_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic req(input int ag, input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                     input logic [W-1:0] exp_rd, input bit to_mem, input bit want_rsp, input bit exp_err);
    req_t r;
    rsp_t e;
    r.wr = wr; r.addr = addr; r.wdata = wd;
    if (ag == 0) aq0.push_back(r); else aq1.push_back(r);
    exp_gnt.push_back(ag);
    if (to_mem) exp_mreq.push_back(r);
    if (want_rsp) begin
      e.agent = ag; e.chk_data = !wr || exp_err; e.rdata = exp_rd; e.err = exp_err;
      exp_rsp.push_back(e);
    end
  endtask

  function automatic bit all_empty();
    return aq0.size() == 0 && aq1.size() == 0 && exp_gnt.size() == 0 &&
           exp_mreq.size() == 0 && exp_rsp.size() == 0;
  endfunction

  task automatic drain(input string name);
    int k = 0;
    while (!all_empty() && k < 300) begin
      @(posedge clk);
      k++;
    end
    check({"drain_", name}, 32'(k >= 300), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_mvalid(input string name);
    int k = 0;
    @(negedge clk);
    while (!m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({"wait_mvalid_", name}, 32'(m_valid), 32'd1);
  endtask

  // Agent drivers: hold the queue front on the request lines until its acceptance edge.
  initial begin
    logic [NA-1:0] acc;
    a_valid = '0; a_wr_rd = '0; a_addr = '0; a_wdata = '0;
    forever begin
      @(negedge clk);
      acc = res ? (a_valid & a_ready) : '0;
      @(posedge clk);
      #1;
      if (acc[0] && aq0.size() > 0) aq0.delete(0);
      if (acc[1] && aq1.size() > 0) aq1.delete(0);
      a_valid[0] = aq0.size() > 0;
      a_valid[1] = aq1.size() > 0;
      a_wr_rd[0] = (aq0.size() > 0) ? aq0[0].wr : 1'b0;
      a_wr_rd[1] = (aq1.size() > 0) ? aq1[0].wr : 1'b0;
      a_addr[0 +: AW]  = (aq0.size() > 0) ? aq0[0].addr : '0;
      a_addr[AW +: AW] = (aq1.size() > 0) ? aq1[0].addr : '0;
      a_wdata[0 +: W]  = (aq0.size() > 0) ? aq0[0].wdata : '0;
      a_wdata[W +: W]  = (aq1.size() > 0) ? aq1[0].wdata : '0;
    end
  end

  // Monitors: grants, memory handshakes and responses popped against the scoreboard.
  initial begin
    logic [NA-1:0] g;
    int   ea;
    req_t er;
    rsp_t ep;
    forever begin
      @(negedge clk);
      if (res) begin
        g = a_valid & a_ready;
        if (g != '0) begin
          if (exp_gnt.size() == 0) check("unexpected_grant", 32'(g), 32'd0);
          else begin
            ea = exp_gnt.pop_front();
            check("grant", 32'(g), 32'd1 << ea);
            acc_cyc.push_back(cyc);
          end
        end
        if (m_valid && m_ready) begin
          last_hs_cyc = cyc;
          if (exp_mreq.size() == 0) check("unexpected_mreq", 32'(m_valid), 32'd0);
          else begin
            er = exp_mreq.pop_front();
            check("m_wr_rd", 32'(m_wr_rd), 32'(er.wr));
            check("m_addr", 32'(m_addr), 32'(er.addr));
            if (er.wr) check("m_wdata", 32'(m_wdata), 32'(er.wdata));
          end
        end
        if (a_rsp_valid != '0) begin
          if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(a_rsp_valid), 32'd0);
          else begin
            ep = exp_rsp.pop_front();
            check("rsp_owner", 32'(a_rsp_valid), 32'd1 << ep.agent);
            check("rsp_err", 32'(a_err), ep.err ? (32'd1 << ep.agent) : 32'd0);
            if (ep.chk_data) check("rsp_rdata", 32'(a_rdata), 32'(ep.rdata));
            if (!ep.err) check("rsp_latency", 32'(cyc - last_hs_cyc), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    int mv_cnt;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    res = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    @(posedge clk);
    #1 res = 1'b1;

    // Single write then read from agent 1.
    req(1, 1'b1, 4'd3, 16'hA5A5, 16'h0000, 1'b1, 1'b1, 1'b0);
    req(1, 1'b0, 4'd3, 16'h0000, 16'hA5A5, 1'b1, 1'b1, 1'b0);
    drain("wr_rd");

    // Reset while agent 0's write is stalled in ISSUE; it must vanish without a response.
    m_ready = 1'b0;
    req(0, 1'b1, 4'd5, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    wait_mvalid("pre_reset");
    @(posedge clk); #1 res = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 res = 1'b1;
    @(negedge clk);
    check("rst2_m_valid", 32'(m_valid), 32'd0);
    check("rst2_m_addr", 32'(m_addr), 32'd0);
    check("rst2_m_wdata", 32'(m_wdata), 32'd0);
    check("rst2_m_wr_rd", 32'(m_wr_rd), 32'd0);
    check("rst2_a_rdata", 32'(a_rdata), 32'd0);
    check("rst2_a_err", 32'(a_err), 32'd0);
    check("rst2_rsp_valid", 32'(a_rsp_valid), 32'd0);
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req(0, 1'b1, 4'd4, 16'h0044, 16'h0000, 1'b1, 1'b1, 1'b0);
    req(1, 1'b1, 4'd6, 16'h0066, 16'h0000, 1'b1, 1'b1, 1'b0);
    drain("post_reset");

    // Round-robin with both agents requesting continuously.
    for (int k = 0; k < 3; k++) begin
      req(0, 1'b1, 4'(8 + k), 16'(16'h1000 + k), 16'h0000, 1'b1, 1'b1, 1'b0);
      req(1, 1'b1, 4'(12 + k), 16'(16'h2000 + k), 16'h0000, 1'b1, 1'b1, 1'b0);
    end
    drain("round_robin");

    // Stalled memory: request fields must hold until m_ready.
    m_ready = 1'b0;
    req(1, 1'b1, 4'd2, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_mvalid("stall");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_m_valid", 32'(m_valid), 32'd1);
      check("stall_m_addr", 32'(m_addr), 32'd2);
      check("stall_m_wdata", 32'(m_wdata), 32'hBEEF);
      check("stall_rsp_quiet", 32'(a_rsp_valid), 32'd0);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    drain("stall");

    // Back-to-back reads from agent 0: one acceptance every 3 cycles.
    acc_cyc.delete();
    req(0, 1'b0, 4'd8, 16'h0000, 16'h1000, 1'b1, 1'b1, 1'b0);
    req(0, 1'b0, 4'd9, 16'h0000, 16'h1001, 1'b1, 1'b1, 1'b0);
    req(0, 1'b0, 4'd10, 16'h0000, 16'h1002, 1'b1, 1'b1, 1'b0);
    drain("b2b");
    check("b2b_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: 16 stalled ISSUE cycles then an error response with a_rdata untouched.
    m_ready = 1'b0;
    mv_cnt = 0;
    req(0, 1'b0, 4'd9, 16'h0000, 16'h1002, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_valid) mv_cnt++;
      if (a_rsp_valid != '0) break;
    end
    check("timeout_issue_cycles", 32'(mv_cnt), 32'd16);
    @(posedge clk); #1 m_ready = 1'b1;
    drain("timeout");
    req(1, 1'b0, 4'd12, 16'h0000, 16'h2000, 1'b1, 1'b1, 1'b0);
    drain("after_timeout");
`else
    mv_cnt = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_req_arb.md
# mem_req_arb

- Multi-agent request arbiter that sits directly upstream of the `memory` block.
- Accepts read/write requests from up to `NUM_AGENTS` independent requesters.
- Grants one request at a time in round-robin order and drives the memory's valid/ready request port.
- Routes the completion (read data or write acknowledge) back to the requester that issued it.

## Interface
Parameters:
- WIDTH, 16, data width; must match the memory's WIDTH
- ADDR_WIDTH, 4, address width; must match the memory's ADDR_WIDTH
- NUM_AGENTS, 2, number of requesters (2..8)
- TIMEOUT, 16, ISSUE-state cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  single clock
- res  in  1  reset; synchronous, active-low
- a_valid  in  NUM_AGENTS  per-agent request valid
- a_ready  out  NUM_AGENTS  per-agent request accept (one-hot or zero)
- a_wr_rd  in  NUM_AGENTS  per-agent direction: 1=write, 0=read
- a_addr  in  NUM_AGENTS*ADDR_WIDTH  flattened addresses; agent i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- a_wdata  in  NUM_AGENTS*WIDTH  flattened write data; agent i at [i*WIDTH +: WIDTH]
- a_rsp_valid  out  NUM_AGENTS  one-cycle completion pulse to the owning agent
- a_rdata  out  WIDTH  shared read-data return; meaningful only alongside a_rsp_valid for a read
- a_err  out  NUM_AGENTS  error flag; meaningful only alongside a_rsp_valid
- m_valid  out  1  memory request valid
- m_wr_rd  out  1  memory direction
- m_addr  out  ADDR_WIDTH  memory address
- m_wdata  out  WIDTH  memory write data
- m_rdata  in  WIDTH  memory read data; valid in the cycle m_ready is high
- m_ready  in  1  memory accept/complete

## Operation
**Reset.** On a clk edge with res==0:
- state=IDLE; rr_ptr=NUM_AGENTS-1, so agent 0 has first priority.
- All outputs are 0: a_ready, a_rsp_valid, a_rdata, a_err, m_valid, m_wr_rd, m_addr, m_wdata.
- An in-flight request is discarded; it gets no response and m_valid is 0 after that edge.

**FSM states.** IDLE, ISSUE, RESP.

**IDLE**
- a_ready is combinational: a one-hot grant to the first asserted a_valid, searching from rr_ptr+1 upward with wrap modulo NUM_AGENTS.
- a_ready is 0 when no a_valid is high.
- On an edge where a_valid[g] & a_ready[g]:
  - latch wr_rd, addr and wdata of agent g;
  - owner=g; rr_ptr=g;
  - go to ISSUE.

**ISSUE**
- m_valid=1; m_wr_rd, m_addr and m_wdata come from the latched registers and are held stable until m_ready.
- a_ready=0 for all agents.
- On an edge with m_ready=1:
  - if the request is a read, capture m_rdata into a_rdata; a write leaves a_rdata unchanged;
  - go to RESP.

**RESP**
- a_rsp_valid[owner]=1 for exactly one cycle; a_err[owner]=0.
- Next state is IDLE.
- m_valid=0 and a_ready=0.

**Arbitration**
- An agent that was just served has the lowest priority in the next arbitration.
- A continuously requesting agent is granted at least once every NUM_AGENTS transactions.
- a_valid changes while in ISSUE or RESP are ignored.

## Timing
- Acceptance edge (IDLE→ISSUE) to m_valid=1: visible from the next cycle.
- m_ready already high in the first ISSUE cycle gives a minimum transaction of 3 cycles: accept, issue, respond.
- a_rsp_valid rises the cycle after the m_ready edge.
- Peak throughput is one transaction per 3 cycles.
- Agents hold their request fields only until their a_ready edge; the arbiter holds the memory-side fields from then on.

## Configuration
MEM_ARB_TIMEOUT_EN is the single compile-time option.

Defined:
- A counter clears on ISSUE entry and increments on each ISSUE cycle with m_ready=0.
- When the counter reaches TIMEOUT-1 with m_ready still 0: drop m_valid on the next edge and go to RESP.
- That RESP asserts a_rsp_valid[owner]=1 and a_err[owner]=1; a_rdata is unchanged.
- Counter width is clog2(TIMEOUT)+1.

Not defined:
- ISSUE waits for m_ready indefinitely.
- No counter is built.
- a_err is tied to 0.

## Test plan
- **Reset mid-ISSUE:** hold res=0 for 2 edges while m_valid=1 → next cycle all outputs are 0 and no a_rsp_valid is seen; the first grant after reset goes to agent 0 when both agents request.
- **Single write/read:** agent 1 writes addr 3 / data 16'hA5A5, then reads addr 3, with the memory model's ready high → m_addr=3 and m_wdata=16'hA5A5 on the write; the read's a_rsp_valid[1] pulse carries a_rdata=16'hA5A5; a_err=0.
- **Round-robin fairness:** NUM_AGENTS=2, both a_valid held high for 6 transactions → grant order 0,1,0,1,0,1; each agent gets 3 rsp pulses.
- **Stalled ready:** m_ready held low 5 cycles → m_valid, m_addr and m_wdata are stable for all 5 cycles; a_rsp_valid appears exactly 1 cycle after m_ready rises.
- **Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=16):** m_ready held low → m_valid drops after 16 ISSUE cycles, then a_rsp_valid[owner]=1 with a_err[owner]=1; the next request proceeds normally.
- **Back-to-back:** agent 0 re-asserts a_valid in the RESP cycle → accepted in the following IDLE cycle; steady state is one transaction every 3 cycles.
